frame_buffer_ctrl: RTL and testbench

- Double-buffered frame memory controller between the host pixel writer and the LED shift-out driver.
- Owns the bank-select for an external dual-port RAM of 2*c_channels words of c_bpc bits.
- Host writes land in the back bank; the driver reads the front bank.
- A host commit swaps the banks at the next driver latch, so a frame is never torn mid-shift.

---
 rtl/frame_buffer_ctrl.sv | 124 ++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame memory controller. The host fills the back bank of
// an external dual-port RAM while the LED driver reads the front bank. A host
// commit freezes the back bank. The banks are then swapped at the next driver
// latch strobe, so a frame is never torn in the middle of a shift-out.
module frame_buffer_ctrl #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic [c_addr_w-1:0] i_wr_addr,
    input  logic [c_bpc-1:0]    i_wr_data,
    input  logic                i_commit,
    input  logic [c_addr_w-1:0] i_drv_addr,
    output logic [c_bpc-1:0]    o_drv_data,
    input  logic                i_frame_sync,
    output logic                o_ram_we,
    output logic [c_addr_w:0]   o_ram_waddr,
    output logic [c_bpc-1:0]    o_ram_wdata,
    output logic [c_addr_w:0]   o_ram_raddr,
    input  logic [c_bpc-1:0]    i_ram_rdata,
    output logic                o_front_bank,
    output logic                o_swap_pending,
    output logic [15:0]         o_frame_count,
    output logic                o_wr_err
);

    typedef enum logic [1:0] {
        s_fill,
        s_pending,
        s_swap
    } state_t;

    state_t      state_q, state_d;
    logic        front_q, front_d;
    logic        sync_prev_q;
    logic [15:0] frame_count_q, frame_count_d;
    logic        wr_err_q, wr_err_d;

    logic        sync_edge;
    logic        wr_accept;
    logic        addr_ok;

    // The zero-extended compare stays correct even when c_channels is a
    // power of two and does not fit in c_addr_w bits.
    assign addr_ok   = ({1'b0, i_wr_addr} < (c_addr_w + 1)'(c_channels));
    assign sync_edge = i_frame_sync & ~sync_prev_q;
    assign wr_accept = i_wr_valid & o_wr_ready;

    assign o_ram_we    = wr_accept & addr_ok;
    assign o_ram_waddr = {~front_q, i_wr_addr};
    assign o_ram_wdata = i_wr_data;
    assign o_ram_raddr = {front_q, i_drv_addr};
    assign o_drv_data  = i_ram_rdata;

    assign o_front_bank  = front_q;
    assign o_frame_count = frame_count_q;
    assign o_wr_err      = wr_err_q;

    // Bank-swap FSM: accept writes, wait for the latch strobe after a commit, then flip banks.
    always_comb begin
        state_d        = state_q;
        front_d        = front_q;
        o_wr_ready     = 1'b0;
        o_swap_pending = 1'b0;
        case (state_q)
            s_fill: begin
                o_wr_ready = 1'b1;
                if (i_commit) begin
                    state_d = s_pending;
                end
            end
            s_pending: begin
                o_swap_pending = 1'b1;
                if (sync_edge) begin
                    state_d = s_swap;
                end
            end
            s_swap: begin
                o_swap_pending = 1'b1;
                front_d        = ~front_q;
                state_d        = s_fill;
            end
            default: begin
                state_d = s_fill;
            end
        endcase
    end

    // Count latch strobes and remember any out-of-range write until reset.
    always_comb begin
        frame_count_d = frame_count_q;
        wr_err_d      = wr_err_q;
        if (sync_edge) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if (wr_accept && !addr_ok) begin
            wr_err_d = 1'b1;
        end
    end

    // State registers. The strobe history resets high so that a strobe held
    // high through reset is not seen as a fresh edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= s_fill;
            front_q       <= 1'b0;
            sync_prev_q   <= 1'b1;
            frame_count_q <= 16'd0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            sync_prev_q   <= i_frame_sync;
            frame_count_q <= frame_count_d;
            wr_err_q      <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Testbench for frame_buffer_ctrl: an external RAM model, a frame-level
// reference model and queue-based scoreboards for RAM writes and driver reads.
module tb_frame_buffer_ctrl;

    localparam int c_channels = 960;

    logic        i_clk;
    logic        i_rst;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [9:0]  i_wr_addr;
    logic [11:0] i_wr_data;
    logic        i_commit;
    logic [9:0]  i_drv_addr;
    logic [11:0] o_drv_data;
    logic        i_frame_sync;
    logic        o_ram_we;
    logic [10:0] o_ram_waddr;
    logic [11:0] o_ram_wdata;
    logic [10:0] o_ram_raddr;
    logic [11:0] i_ram_rdata;
    logic        o_front_bank;
    logic        o_swap_pending;
    logic [15:0] o_frame_count;
    logic        o_wr_err;

    frame_buffer_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_commit       (i_commit),
        .i_drv_addr     (i_drv_addr),
        .o_drv_data     (o_drv_data),
        .i_frame_sync   (i_frame_sync),
        .o_ram_we       (o_ram_we),
        .o_ram_waddr    (o_ram_waddr),
        .o_ram_wdata    (o_ram_wdata),
        .o_ram_raddr    (o_ram_raddr),
        .i_ram_rdata    (i_ram_rdata),
        .o_front_bank   (o_front_bank),
        .o_swap_pending (o_swap_pending),
        .o_frame_count  (o_frame_count),
        .o_wr_err       (o_wr_err)
    );

    int checks = 0;
    int errors = 0;

    // External dual-port RAM with a registered read port.
    logic [11:0] ram [0:2047];
    // Reference image of what the RAM should hold.
    logic [11:0] ref_mem [0:2047];

    logic [22:0] wq[$];
    logic [11:0] rq[$];
    bit          rd_req = 1'b0;
    bit          rd_req_d = 1'b0;

    // Frame-level model state.
    bit          m_front;
    bit          m_pending;
    bit          m_swap_next;
    logic [15:0] m_count;
    bit          m_err;
    bit          m_prev_sync;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_ram_we === 1'b1) ram[o_ram_waddr] <= o_ram_wdata;
        i_ram_rdata <= ram[o_ram_raddr];
        rd_req_d    <= rd_req;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Write monitor: every RAM write must match the oldest expected write.
    always @(negedge i_clk) begin
        if (o_ram_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("spurious_write", {21'd0, o_ram_waddr}, 32'hFFFF_FFFF);
            end else begin
                check("ram_write", {9'd0, o_ram_waddr, o_ram_wdata}, {9'd0, wq.pop_front()});
            end
        end
    end

    // Read monitor: driver data is due one cycle after the address was presented.
    always @(negedge i_clk) begin
        if (rd_req_d) begin
            if (rq.size() == 0) begin
                check("read_underflow", 32'd0, 32'd1);
            end else begin
                check("drv_data", {20'd0, o_drv_data}, {20'd0, rq.pop_front()});
            end
        end
    end

    task automatic checkOutput(input bit exp_ready, input bit exp_we, input logic [10:0] exp_raddr);
        check("wr_ready", {31'd0, o_wr_ready}, {31'd0, exp_ready});
        check("ram_we", {31'd0, o_ram_we}, {31'd0, exp_we});
        check("ram_raddr", {21'd0, o_ram_raddr}, {21'd0, exp_raddr});
        check("front_bank", {31'd0, o_front_bank}, {31'd0, m_front});
        check("swap_pending", {31'd0, o_swap_pending}, {31'd0, m_pending});
        check("frame_count", {16'd0, o_frame_count}, {16'd0, m_count});
        check("wr_err", {31'd0, o_wr_err}, {31'd0, m_err});
    endtask

    task automatic modelReset();
        m_front     = 1'b0;
        m_pending   = 1'b0;
        m_swap_next = 1'b0;
        m_count     = 16'd0;
        m_err       = 1'b0;
        m_prev_sync = 1'b1;
    endtask

    task automatic doReset(input bit sync);
        i_rst        = 1'b1;
        i_wr_valid   = 1'b0;
        i_commit     = 1'b0;
        i_frame_sync = sync;
        rd_req       = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelReset();
    endtask

    // One cycle of stimulus; called 1 time unit after a rising edge.
    task automatic applyStimulus(input bit v, input int addr, input int data,
                                 input bit commit, input bit sync, input int daddr);
        bit          exp_ready, rise, acc, exp_we, was_pending;
        logic [10:0] widx, ridx;
        i_wr_valid   = v;
        i_wr_addr    = addr[9:0];
        i_wr_data    = data[11:0];
        i_commit     = commit;
        i_frame_sync = sync;
        i_drv_addr   = daddr[9:0];
        rd_req       = 1'b1;

        exp_ready = !m_pending;
        rise      = sync && !m_prev_sync;
        acc       = v && exp_ready;
        exp_we    = acc && (addr < c_channels);
        widx      = {~m_front, addr[9:0]};
        ridx      = {m_front, daddr[9:0]};
        rq.push_back(ref_mem[ridx]);
        if (exp_we) begin
            wq.push_back({widx, data[11:0]});
            ref_mem[widx] = data[11:0];
        end

        @(negedge i_clk);
        checkOutput(exp_ready, exp_we, ridx);
        @(posedge i_clk);

        was_pending = m_pending;
        if (m_swap_next) begin
            m_swap_next = 1'b0;
            m_front     = !m_front;
            m_pending   = 1'b0;
        end else if (was_pending && rise) begin
            m_swap_next = 1'b1;
        end
        if (!was_pending && commit) m_pending = 1'b1;
        if (rise) m_count = m_count + 16'd1;
        if (acc && addr >= c_channels) m_err = 1'b1;
        m_prev_sync = sync;
        #1;
    endtask

    task automatic idle(input int n, input int daddr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, daddr);
    endtask

    initial begin
        bit sync_r;
        for (int i = 0; i < 2048; i++) begin
            ram[i]     = 12'd0;
            ref_mem[i] = 12'd0;
        end
        i_wr_addr  = 10'd0;
        i_wr_data  = 12'd0;
        i_drv_addr = 10'd0;
        doReset(1'b0);

        // Write, commit, strobe; then read the swapped-in value back.
        applyStimulus(1, 5, 'hABC, 0, 0, 5);
        check("t1_waddr_bank1", {21'd0, wq.size() == 0 ? 11'h405 : 11'h000}, 32'h405);
        applyStimulus(0, 0, 0, 1, 0, 5);
        applyStimulus(0, 0, 0, 0, 1, 5);
        idle(4, 5);

        // Frozen back bank: writes are refused until the swap completes.
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, i, 'h100 + i, 0, 0, 5);
        applyStimulus(1, 7, 'h777, 0, 1, 5);
        applyStimulus(1, 8, 'h888, 0, 0, 5);
        applyStimulus(1, 9, 'h999, 0, 0, 5);
        idle(2, 9);

        // Commit and strobe in the same cycle: swap waits for the next strobe.
        applyStimulus(0, 0, 0, 1, 1, 0);
        idle(3, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(3, 7);

        // Out-of-range write sets the sticky error.
        applyStimulus(1, c_channels, 'h555, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 10 + i, 'h200 + i, 0, 0, 0);
        applyStimulus(1, 1023, 'h321, 0, 0, 0);
        doReset(1'b0);
        idle(2, 0);

        // Strobe held high for 3 cycles: one swap, one count.
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        idle(3, 12);

        // Reset while pending, strobe held high through reset.
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        doReset(1'b1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(2, 5);

        // Randomized traffic.
        sync_r = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            int a;
            if ($urandom_range(0, 5) == 0) sync_r = !sync_r;
            a = ($urandom_range(0, 199) == 0) ? $urandom_range(c_channels, 1023) : $urandom_range(0, 15);
            if ($urandom_range(0, 299) == 0) begin
                doReset($urandom_range(0, 1) == 1);
            end else begin
                applyStimulus($urandom_range(0, 1) == 1, a, $urandom_range(0, 4095),
                              $urandom_range(0, 19) == 0, sync_r, $urandom_range(0, 15));
            end
        end

        rd_req     = 1'b0;
        i_wr_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("write_queue_drained", wq.size(), 0);
        check("read_queue_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
